// File: rtl/vx_ag_tcu_kstep_ctrl_if.sv
// vx_ag_tcu_kstep_ctrl_if: operand, FEDP and result bundle for the k-step controller
interface vx_ag_tcu_kstep_ctrl_if #(
   parameter int N     = 4,
   parameter int SLOTS = 4,
   parameter int XLEN  = 32
);
   localparam int SLOTW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   logic                in_valid;
   logic                in_ready;
   logic [SLOTW-1:0]    in_slot;
   logic                in_first;
   logic                in_last;
   logic [2:0]          in_fmt_s;
   logic [2:0]          in_fmt_d;
   logic [N*XLEN-1:0]   in_a;
   logic [N*XLEN-1:0]   in_b;
   logic [XLEN-1:0]     in_c;
   logic                fedp_enable;
   logic [2:0]          fedp_fmt_s;
   logic [2:0]          fedp_fmt_d;
   logic [N*XLEN-1:0]   fedp_a_row;
   logic [N*XLEN-1:0]   fedp_b_col;
   logic [XLEN-1:0]     fedp_c_val;
   logic [XLEN-1:0]     fedp_d_val;
   logic                out_valid;
   logic                out_ready;
   logic [SLOTW-1:0]    out_slot;
   logic [XLEN-1:0]     out_data;
   logic                busy;
   modport master (
      output in_valid, in_slot, in_first, in_last, in_fmt_s, in_fmt_d, in_a, in_b, in_c,
      output fedp_d_val, out_ready,
      input  in_ready, fedp_enable, fedp_fmt_s, fedp_fmt_d, fedp_a_row, fedp_b_col, fedp_c_val,
      input  out_valid, out_slot, out_data, busy
   );
   modport slave (
      input  in_valid, in_slot, in_first, in_last, in_fmt_s, in_fmt_d, in_a, in_b, in_c,
      input  fedp_d_val, out_ready,
      output in_ready, fedp_enable, fedp_fmt_s, fedp_fmt_d, fedp_a_row, fedp_b_col, fedp_c_val,
      output out_valid, out_slot, out_data, busy
   );
endinterface

// File: rtl/vx_ag_tcu_kstep_ctrl.sv
// vx_ag_tcu_kstep_ctrl: k-step accumulation control around a fixed-latency FEDP (perf counters under AG_TCU_KSTEP_PERF_EN)
module vx_ag_tcu_kstep_ctrl #(
   parameter int N       = 4,
   parameter int LATENCY = 5,
   parameter int SLOTS   = 4,
   parameter int XLEN    = 32
) (
   input logic                  clk,
   input logic                  reset,
   vx_ag_tcu_kstep_ctrl_if.slave bus
`ifdef AG_TCU_KSTEP_PERF_EN
   ,
   output logic [31:0]          perf_issues,
   output logic [31:0]          perf_stalls
`endif
);
   localparam int SLOTW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam int NS    = 1 << SLOTW;

   if (LATENCY < 2 || (N & (N - 1)) != 0 || (SLOTS & (SLOTS - 1)) != 0) begin : g_bad_cfg
      $error("vx_ag_tcu_kstep_ctrl: invalid parameters");
   end

   logic [LATENCY:1]  r_vld;
   logic [LATENCY:1]  r_last;
   logic [SLOTW-1:0]  r_slot [1:LATENCY];
   logic [XLEN-1:0]   r_acc [NS];
   logic              r_out_valid;
   logic [SLOTW-1:0]  r_out_slot;
   logic [XLEN-1:0]   r_out_data;
   logic              w_en;
   logic              w_issue;
   logic              w_retire;
   logic              w_fwd;
   logic [NS-1:0]     w_busy;

   // a slot is busy while one of its beats sits before the last stage; the last stage is covered by forwarding
   always_comb begin
      w_busy = '0;
      for (int k = 1; k < LATENCY; k++)
         if (r_vld[k]) w_busy[r_slot[k]] = 1'b1;
   end

   assign w_en     = !r_out_valid || bus.out_ready;
   assign w_issue  = bus.in_valid && bus.in_ready;
   assign w_retire = w_en && r_vld[LATENCY];
   assign w_fwd    = r_vld[LATENCY] && (r_slot[LATENCY] == bus.in_slot);

   assign bus.in_ready    = w_en && !w_busy[bus.in_slot];
   assign bus.fedp_enable = w_en;
   assign bus.fedp_fmt_s  = bus.in_fmt_s;
   assign bus.fedp_fmt_d  = bus.in_fmt_d;
   assign bus.fedp_a_row  = bus.in_a;
   assign bus.fedp_b_col  = bus.in_b;
   assign bus.fedp_c_val  = bus.in_first ? bus.in_c : w_fwd ? bus.fedp_d_val : r_acc[bus.in_slot];
   assign bus.out_valid   = r_out_valid;
   assign bus.out_slot    = r_out_slot;
   assign bus.out_data    = r_out_data;
   assign bus.busy        = (|r_vld) || r_out_valid;

   // tracking valids advance with the FEDP pipeline; bubbles enter when nothing issues
   always_ff @(posedge clk) begin
      if (reset) r_vld <= '0;
      else if (w_en) r_vld <= {r_vld[LATENCY-1:1], w_issue};
   end

   // slot/last tags ride alongside the valids and need no reset
   always_ff @(posedge clk) begin
      if (w_en) begin
         r_last    <= {r_last[LATENCY-1:1], bus.in_last};
         r_slot[1] <= bus.in_slot;
         for (int k = 2; k <= LATENCY; k++) r_slot[k] <= r_slot[k-1];
      end
   end

   // retiring beats update their slot accumulator
   always_ff @(posedge clk) begin
      if (reset) for (int k = 0; k < NS; k++) r_acc[k] <= '0;
      else if (w_retire) r_acc[r_slot[LATENCY]] <= bus.fedp_d_val;
   end

   // final k-step loads the result register; a consumed result clears unless replaced
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_out_slot  <= '0;
         r_out_data  <= '0;
      end else if (w_retire && r_last[LATENCY]) begin
         r_out_valid <= 1'b1;
         r_out_slot  <= r_slot[LATENCY];
         r_out_data  <= bus.fedp_d_val;
      end else if (bus.out_ready) r_out_valid <= 1'b0;
   end

`ifdef AG_TCU_KSTEP_PERF_EN
   // issue and stall counters wrap naturally at 32 bits
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_issues <= '0;
         perf_stalls <= '0;
      end else begin
         perf_issues <= perf_issues + {31'd0, w_issue};
         perf_stalls <= perf_stalls + {31'd0, bus.in_valid && !bus.in_ready};
      end
   end
`endif
endmodule

// File: tb/tb_vx_ag_tcu_kstep_ctrl.sv
// tb_vx_ag_tcu_kstep_ctrl: table vectors, timing sequences and randomized scoreboard for the k-step controller
module tb_vx_ag_tcu_kstep_ctrl;
   localparam int N = 4, LAT = 5, SLOTS = 4, XLEN = 32;

   logic clk, reset;
   int   n_tests = 0, n_fail = 0;

   vx_ag_tcu_kstep_ctrl_if #(.N(N), .SLOTS(SLOTS), .XLEN(XLEN)) bus ();

`ifdef AG_TCU_KSTEP_PERF_EN
   logic [31:0] perf_issues, perf_stalls;
   vx_ag_tcu_kstep_ctrl #(.N(N), .LATENCY(LAT), .SLOTS(SLOTS), .XLEN(XLEN)) dut (
      .clk(clk), .reset(reset), .bus(bus), .perf_issues(perf_issues), .perf_stalls(perf_stalls));
`else
   vx_ag_tcu_kstep_ctrl #(.N(N), .LATENCY(LAT), .SLOTS(SLOTS), .XLEN(XLEN)) dut (
      .clk(clk), .reset(reset), .bus(bus));
`endif

   initial clk = 0;
   always #5 clk = ~clk;

   // packed integer dot product over all lanes: 8-bit or 4-bit elements, signed or unsigned
   function automatic logic [XLEN-1:0] dot(input logic [N*XLEN-1:0] a, input logic [N*XLEN-1:0] b, input logic [2:0] f);
      int s, ew, va, vb;
      logic [N*XLEN-1:0] ta, tbv;
      s  = 0;
      ew = (f >= 3'd3) ? 4 : 8;
      for (int l = 0; l < N*XLEN/ew; l++) begin
         ta  = a >> (l*ew);
         tbv = b >> (l*ew);
         va  = (ew == 8) ? int'(ta[7:0]) : int'(ta[3:0]);
         vb  = (ew == 8) ? int'(tbv[7:0]) : int'(tbv[3:0]);
         if (f == 3'd1) begin
            if (va > 127) va -= 256;
            if (vb > 127) vb -= 256;
         end
         if (f == 3'd3) begin
            if (va > 7) va -= 16;
            if (vb > 7) vb -= 16;
         end
         s += va * vb;
      end
      return XLEN'(s);
   endfunction

   // downstream FEDP: fixed LAT-stage pipeline frozen by fedp_enable
   logic [XLEN-1:0] fp [1:LAT];
   always @(posedge clk) begin
      if (bus.fedp_enable) begin
         fp[1] <= dot(bus.fedp_a_row, bus.fedp_b_col, bus.fedp_fmt_s) + bus.fedp_c_val;
         for (int k = 2; k <= LAT; k++) fp[k] <= fp[k-1];
      end
   end
   assign bus.fedp_d_val = fp[LAT];

   task automatic chk(input string name, input logic [N*XLEN-1:0] act, input logic [N*XLEN-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // scoreboard: per-slot sequential accumulation, results expected in issue order
   typedef struct { logic [1:0] slot; logic [XLEN-1:0] data; } res_t;
   res_t            q[$];
   logic [XLEN-1:0] m_acc [SLOTS];
   always @(negedge clk) begin
      if (reset) begin
         q.delete();
         for (int s = 0; s < SLOTS; s++) m_acc[s] = '0;
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            n_tests++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL sb_extra: got result slot %0d data %0h, expected none", bus.out_slot, bus.out_data);
            end else begin
               res_t r;
               r = q.pop_front();
               chk("sb_data", bus.out_data, r.data);
               chk("sb_slot", bus.out_slot, r.slot);
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            m_acc[bus.in_slot] = (bus.in_first ? bus.in_c : m_acc[bus.in_slot]) + dot(bus.in_a, bus.in_b, bus.in_fmt_s);
            if (bus.in_last) q.push_back('{bus.in_slot, m_acc[bus.in_slot]});
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic put(input int slot, input bit first, input bit last, input logic [2:0] fmt,
                      input logic [31:0] aw, input logic [31:0] bw, input logic [31:0] c);
      bus.in_valid = 1;
      bus.in_slot  = 2'(slot);
      bus.in_first = first;
      bus.in_last  = last;
      bus.in_fmt_s = fmt;
      bus.in_fmt_d = fmt;
      bus.in_a     = {N{aw}};
      bus.in_b     = {N{bw}};
      bus.in_c     = c;
   endtask

   task automatic drain;
      for (int i = 0; i < 300 && bus.busy; i++) tick;
      chk("drain_busy", bus.busy, 0);
   endtask

   typedef struct { int slot; logic [2:0] fmt; logic [31:0] a, b, c, exp; } vec_t;
   vec_t tbl[6];

   initial begin
      logic [XLEN-1:0] cap;
      int lows, w;
      tbl[0] = '{0, 3'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,   32'd7200};
      tbl[1] = '{1, 3'd1, 32'hFFFFFFFF, 32'h02020202, 32'd0,   32'hFFFFFFE0};
      tbl[2] = '{2, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,   32'd1040400};
      tbl[3] = '{3, 3'd3, 32'hFFFFFFFF, 32'h11111111, 32'd100, 32'd68};
      tbl[4] = '{0, 3'd1, 32'h7F7F7F7F, 32'h80808080, 32'd0,   32'hFFFC0800};
      tbl[5] = '{1, 3'd4, 32'h12345678, 32'h11111111, 32'd5,   32'd149};

      reset = 1;
      bus.out_ready = 1;
      put(0, 0, 0, 3'd1, 0, 0, 0);
      bus.in_valid = 0;
      repeat (3) tick;
      reset = 0;
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_fedp_en", bus.fedp_enable, 1);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_slot", bus.out_slot, 0);

      // single-beat first+last vectors
      foreach (tbl[i]) begin
         put(tbl[i].slot, 1, 1, tbl[i].fmt, tbl[i].a, tbl[i].b, tbl[i].c);
         #1;
         chk("tbl_a_row", bus.fedp_a_row, {N{tbl[i].a}});
         chk("tbl_c_val", bus.fedp_c_val, tbl[i].c);
         for (int k = 0; k < 50 && !bus.in_ready; k++) tick;
         chk("tbl_ready", bus.in_ready, 1);
         tick;
         bus.in_valid = 0;
         for (int k = 0; k < 4*LAT && !bus.out_valid; k++) tick;
         chk("tbl_out_valid", bus.out_valid, 1);
         chk("tbl_out_data", bus.out_data, tbl[i].exp);
         chk("tbl_out_slot", bus.out_slot, tbl[i].slot);
         tick;
      end
      drain;

      // two-beat chain on slot 0: issue spacing and result timing
      put(0, 1, 0, 3'd1, 32'h01010101, 32'h01010101, 32'd10);
      #1;
      chk("k2_ready_t0", bus.in_ready, 1);
      tick;
      put(0, 0, 1, 3'd1, 32'h01010101, 32'h01010101, 32'd0);
      for (int k = 1; k <= 4; k++) begin
         #1;
         chk("k2_ready_low", bus.in_ready, 0);
         tick;
      end
      #1;
      chk("k2_ready_t5", bus.in_ready, 1);
      tick;
      bus.in_valid = 0;
      for (int k = 6; k <= 11; k++) begin
         if (k < 11) chk("k2_out_early", bus.out_valid, 0);
         else begin
            chk("k2_out_valid", bus.out_valid, 1);
            chk("k2_out_data", bus.out_data, 42);
         end
         tick;
      end
      drain;

      // slots 0..3 back to back, then slot 0 waits exactly one cycle
      for (int s = 0; s < 4; s++) begin
         put(s, 1, 1, 3'd2, $urandom, $urandom, $urandom);
         #1;
         chk("rr_ready", bus.in_ready, 1);
         tick;
      end
      put(0, 1, 1, 3'd1, $urandom, $urandom, $urandom);
      #1;
      lows = 0;
      while (!bus.in_ready && lows < 20) begin
         lows++;
         tick;
      end
      chk("rr_low_cycles", lows, 1);
      tick;
      bus.in_valid = 0;
      drain;

      // backpressure with one result pending and another slot in flight
      bus.out_ready = 0;
      put(0, 1, 1, 3'd2, 32'h01020304, 32'h01010101, 32'd1);
      tick;
      put(1, 1, 1, 3'd3, 32'h89ABCDEF, 32'h76543210, 32'd7);
      tick;
      bus.in_valid = 0;
      bus.in_slot  = 2;
      for (w = 0; w < 20 && !bus.out_valid; w++) tick;
      chk("bp_out_valid", bus.out_valid, 1);
      cap = bus.out_data;
      chk("bp_pending", q.size(), 2);
      for (int k = 0; k < 6; k++) begin
         chk("bp_fedp_en", bus.fedp_enable, 0);
         chk("bp_in_ready", bus.in_ready, 0);
         chk("bp_data_stable", bus.out_data, cap);
         tick;
      end
      bus.out_ready = 1;
      drain;
      chk("bp_all_delivered", q.size(), 0);

      // randomized traffic against the scoreboard
      for (int k = 0; k < 3000; k++) begin
         put($urandom_range(0, 3), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) != 0),
             3'($urandom_range(1, 4)), $urandom, $urandom, $urandom);
         bus.in_a      = {$urandom, $urandom, $urandom, $urandom};
         bus.in_valid  = ($urandom_range(0, 9) < 8);
         bus.out_ready = ($urandom_range(0, 9) < 7);
         tick;
      end
      bus.in_valid  = 0;
      bus.out_ready = 1;
      drain;
      chk("rand_all_delivered", q.size(), 0);

      // reset with three beats in flight
      for (int s = 0; s < 3; s++) begin
         put(s, 1, 1, 3'd1, $urandom, $urandom, $urandom);
         tick;
      end
      bus.in_valid = 0;
      reset = 1;
      tick;
      reset = 0;
      chk("rst_mid_busy", bus.busy, 0);
      lows = 0;
      for (int k = 0; k < 2*LAT; k++) begin
         if (bus.out_valid) lows++;
         tick;
      end
      chk("rst_mid_no_out", lows, 0);

      // after reset the accumulators restart from zero
      put(3, 0, 1, 3'd2, 32'h01010101, 32'h02020202, 32'd999);
      #1;
      chk("rst_acc_c", bus.fedp_c_val, 0);
      tick;
      bus.in_valid = 0;
      drain;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
